// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clock divider bank.
// half_up gives the high-phase length of a divisor: ceil(P/2) without overflow.
package clk_div_pkg;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_WIDTH    = 16;

    typedef logic [DEF_WIDTH-1:0] div_t;

    function automatic div_t half_up(div_t p);
        return (p >> 1) + div_t'(p[0]);
    endfunction
endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending divisor, registered wave and tick.
// Pending divisors only land on a boundary (wrap, disabled, or sync).
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_DIV = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sync,
    output logic             div_out,
    output logic             tick,
    output logic             pend
);
    logic [WIDTH-1:0] cnt_q, cnt_d, p_q, p_d, nxt_q, nxt_d, half_d;
    logic             pend_q, pend_d, div_out_q, div_out_d, tick_q, tick_d;
    logic             wrap, boundary;

    always_comb begin
        wrap     = (p_q != '0) && (cnt_q == p_q - WIDTH'(1));
        boundary = sync || wrap || (p_q == '0);
        cnt_d    = boundary ? '0 : cnt_q + WIDTH'(1);
        p_d      = p_q;
        nxt_d    = nxt_q;
        pend_d   = pend_q;
        // pend_q is the registered flag, so a write never applies in its own accept cycle
        if (pend_q && boundary) begin
            p_d    = nxt_q;
            pend_d = 1'b0;
        end
        if (load) begin
            nxt_d  = load_val;
            pend_d = 1'b1;
        end
        half_d    = (p_d >> 1) + WIDTH'(p_d[0]);
        div_out_d = (p_d != '0) && (cnt_d < half_d);
        tick_d    = (p_d != '0) && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q     <= '0;
            p_q       <= RESET_DIV;
            nxt_q     <= '0;
            pend_q    <= 1'b0;
            div_out_q <= (RESET_DIV != '0);
            tick_q    <= (RESET_DIV != '0);
        end else begin
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            nxt_q     <= nxt_d;
            pend_q    <= pend_d;
            div_out_q <= div_out_d;
            tick_q    <= tick_d;
        end
    end

    assign div_out = div_out_q;
    assign tick    = tick_q;
    assign pend    = pend_q;
endmodule

// File: rtl/clk_div_bank.sv
// Bank of programmable clock dividers with a shared config port and global sync.
// Top level is decode only; all state lives in the per-channel instances.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int          CHANNELS  = DEF_CHANNELS,
    parameter int          WIDTH     = DEF_WIDTH,
    parameter int unsigned RESET_DIV = 0,
    parameter int          CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_chan,
    input  logic [WIDTH-1:0]    cfg_div,
    input  logic                sync,
    output logic [CHANNELS-1:0] div_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);
    logic [CHANNELS-1:0] pend_w, load;
    logic [2**CW-1:0]    pend_pad;
    logic                accept;

    always_comb begin
        // Zero padding makes out-of-range indices always ready; their writes match no channel.
        pend_pad                 = '0;
        pend_pad[CHANNELS-1:0]   = pend_w;
        cfg_ready                = !pend_pad[cfg_chan];
        accept                   = cfg_valid && cfg_ready;
        load                     = '0;
        for (int i = 0; i < CHANNELS; i++)
            load[i] = accept && (32'(cfg_chan) == 32'(i));
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        clk_div_chan #(
            .WIDTH    (WIDTH),
            .RESET_DIV(WIDTH'(RESET_DIV))
        ) u_chan (
            .clk     (clk),
            .resetn  (resetn),
            .load    (load[g]),
            .load_val(cfg_div),
            .sync    (sync),
            .div_out (div_out[g]),
            .tick    (tick[g]),
            .pend    (pend_w[g])
        );
    end

    assign pending = pend_w;
endmodule

// File: tb/tb_clk_div_bank.sv
// Directed and random stimulus for clk_div_bank against a per-channel arithmetic model.
module tb_clk_div_bank;
    localparam int CH = 3;
    localparam int W  = 16;
    localparam int CW = 2;

    logic          clk = 1'b0, resetn = 1'b0, cfg_valid = 1'b0, sync = 1'b0;
    logic [CW-1:0] cfg_chan = '0;
    logic [W-1:0]  cfg_div = '0;
    logic          cfg_ready;
    logic [CH-1:0] div_out, tick, pending;

    int total = 0, bad = 0;
    int unsigned m_cnt[CH], m_p[CH], m_nxt[CH];
    bit          m_pend[CH];

    clk_div_bank #(.CHANNELS(CH), .WIDTH(W), .RESET_DIV(0)) dut (
        .clk(clk), .resetn(resetn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_div(cfg_div), .sync(sync),
        .div_out(div_out), .tick(tick), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ready();
        if (int'(cfg_chan) >= CH) return 1'b1;
        return !m_pend[cfg_chan];
    endfunction

    function automatic logic [CH-1:0] exp_div();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = (m_p[i] != 0) && (m_cnt[i] < (m_p[i] + 1) / 2);
        return v;
    endfunction

    function automatic logic [CH-1:0] exp_tick();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = (m_p[i] != 0) && (m_cnt[i] == 0);
        return v;
    endfunction

    function automatic logic [CH-1:0] exp_pend();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_update();
        bit acc;
        bit bnd;
        acc = cfg_valid && exp_ready();
        if (!resetn) begin
            for (int i = 0; i < CH; i++) begin
                m_cnt[i] = 0; m_p[i] = 0; m_nxt[i] = 0; m_pend[i] = 0;
            end
            return;
        end
        for (int i = 0; i < CH; i++) begin
            bnd = sync || (m_p[i] == 0) || (m_cnt[i] == m_p[i] - 1);
            if (m_pend[i] && bnd) begin
                m_p[i] = m_nxt[i]; m_cnt[i] = 0; m_pend[i] = 0;
            end else if (sync || m_p[i] == 0) m_cnt[i] = 0;
            else m_cnt[i] = (m_cnt[i] + 1) % m_p[i];
        end
        if (acc && int'(cfg_chan) < CH) begin
            m_nxt[cfg_chan] = cfg_div;
            m_pend[cfg_chan] = 1'b1;
        end
    endtask

    task automatic step();
        #1;
        chk("ready", 32'(cfg_ready), 32'(exp_ready()));
        @(posedge clk);
        model_update();
        #1;
        chk("div_out", 32'(div_out), 32'(exp_div()));
        chk("tick", 32'(tick), 32'(exp_tick()));
        chk("pending", 32'(pending), 32'(exp_pend()));
    endtask

    initial begin
        int r;
        for (int i = 0; i < CH; i++) begin
            m_cnt[i] = 0; m_p[i] = 0; m_nxt[i] = 0; m_pend[i] = 0;
        end
        // reset state
        step(); step();
        chk("rst_div", 32'(div_out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_pend", 32'(pending), 0);
        resetn = 1'b1;
        repeat (7) step();

        // ch0 := 4 from disabled
        cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_div = 16'd4;
        step();
        cfg_valid = 1'b0;
        chk("t1_pend", 32'(pending[0]), 1);
        chk("t1_notick", 32'(tick[0]), 0);
        step();
        chk("t1_tick", 32'(tick[0]), 1);
        chk("t1_div0", 32'(div_out[0]), 1);
        chk("t1_pclr", 32'(pending[0]), 0);
        for (int k = 1; k < 8; k++) begin
            step();
            chk("t1_wave", 32'(div_out[0]), 32'((k % 4) < 2));
        end

        // ch1 := 5, then 2 written at cnt=1, then 3 written while pending
        cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_div = 16'd5;
        step();
        cfg_valid = 1'b0;
        step();
        chk("t2_tick5", 32'(tick[1]), 1);
        step();
        cfg_valid = 1'b1; cfg_div = 16'd2;
        step();
        cfg_div = 16'd3;
        chk("t2_pend", 32'(pending[1]), 1);
        chk("t2_c2", 32'(div_out[1]), 1);
        #1 chk("t3_stall0", 32'(cfg_ready), 0);
        step();
        chk("t2_c3", 32'(div_out[1]), 0);
        #1 chk("t3_stall1", 32'(cfg_ready), 0);
        step();
        chk("t2_c4", 32'(div_out[1]), 0);
        chk("t2_pend4", 32'(pending[1]), 1);
        step();
        chk("t2_apply_tick", 32'(tick[1]), 1);
        chk("t2_apply_div", 32'(div_out[1]), 1);
        chk("t2_apply_pend", 32'(pending[1]), 0);
        #1 chk("t3_ready", 32'(cfg_ready), 1);
        step();
        cfg_valid = 1'b0;
        chk("t3_pend", 32'(pending[1]), 1);
        chk("t3_p2low", 32'(div_out[1]), 0);
        step();
        chk("t3_apply", 32'(tick[1]), 1);
        chk("t3_pclr", 32'(pending[1]), 0);

        // ch2 := 7, then sync aligns P=4,3,7
        cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_div = 16'd7;
        step();
        cfg_valid = 1'b0;
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("t4_sync", 32'(tick), 32'h7);
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("t4_off4", 32'(tick[0]), 32'(k % 4 == 0));
            chk("t4_off3", 32'(tick[1]), 32'(k % 3 == 0));
            chk("t4_off7", 32'(tick[2]), 32'(k % 7 == 0));
        end

        // accept on ch2 coincident with sync stays pending
        cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_div = 16'd5; sync = 1'b1;
        step();
        cfg_valid = 1'b0; sync = 1'b0;
        chk("t5_pend", 32'(pending[2]), 1);
        chk("t5_tick", 32'(tick[2]), 1);
        repeat (6) step();
        chk("t5_hold", 32'(pending[2]), 1);
        step();
        chk("t5_apply", 32'(tick[2]), 1);
        chk("t5_pclr", 32'(pending), 0);
        cfg_valid = 1'b1; cfg_chan = 2'(CH); cfg_div = 16'd7;
        #1 chk("t5_oor_ready", 32'(cfg_ready), 1);
        step();
        cfg_valid = 1'b0;
        chk("t5_oor_pend", 32'(pending), 0);
        step();
        chk("t5_oor_pend2", 32'(pending), 0);

        // reset mid-pending
        cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_div = 16'd9;
        step();
        cfg_valid = 1'b0;
        chk("t6_pend", 32'(pending[0]), 1);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("t6_pclr", 32'(pending), 0);
        chk("t6_div", 32'(div_out), 0);
        chk("t6_tick", 32'(tick), 0);
        #1 chk("t6_ready", 32'(cfg_ready), 1);

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            resetn    = ($urandom_range(0, 59) != 0);
            sync      = ($urandom_range(0, 19) == 0);
            cfg_valid = 1'($urandom_range(0, 1));
            cfg_chan  = 2'($urandom_range(0, 3));
            r         = $urandom_range(0, 15);
            cfg_div   = (r == 15) ? 16'hFFFF : 16'(r % 10);
            step();
        end
        resetn = 1'b1; sync = 1'b0; cfg_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
